// File: rtl/digilent_basys3_pkg.sv
// Shared UART state encodings and bit-timing helpers for the Basys3 echo design.
package digilent_basys3_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                                input int unsigned baud);
      return clk_freq_hz / baud;
   endfunction

   // Counters run 0..CLKS_PER_BIT-1; keep at least one bit for tiny ratios.
   function automatic int unsigned bit_cnt_width(input int unsigned cpb);
      return (cpb > 1) ? $clog2(cpb) : 1;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, one-cycle
// rx_valid / frame_err pulses.
module uart_rx
   import digilent_basys3_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       frame_err_o
);

   localparam int unsigned CW   = bit_cnt_width(CLKS_PER_BIT);
   localparam int unsigned HALF = (CLKS_PER_BIT >= 2) ? CLKS_PER_BIT / 2 : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_valid_o  <= 1'b0;
         rx_data_o   <= '0;
         frame_err_o <= 1'b0;
      end else begin
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_sync_q) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[7:1]};
                  if (bit_q == 3'd7) state_q <= RX_STOP;
                  else               bit_q   <= bit_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (rx_sync_q) begin
                     rx_valid_o <= 1'b1;
                     rx_data_o  <= shift_q;
                     state_q    <= RX_IDLE;
                  end else begin
                     frame_err_o <= 1'b1;
                     state_q     <= RX_WAIT_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_WAIT_IDLE: begin
               if (rx_sync_q) state_q <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/digilent_basys3.sv
// Basys3 UART echo: received bytes shown on LEDs, counted, and echoed back
// through a transmitter with a one-entry holding register.
module digilent_basys3
   import digilent_basys3_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BAUD        = 115_200
) (
   input  logic clk100,
   input  logic user_btnc,
   input  logic serial_rx,
   output logic serial_tx,
   output logic user_led0,
   output logic user_led1,
   output logic user_led2,
   output logic user_led3,
   output logic user_led4,
   output logic user_led5,
   output logic user_led6,
   output logic user_led7,
   output logic user_led8,
   output logic user_led9,
   output logic user_led10,
   output logic user_led11,
   output logic user_led12,
   output logic user_led13,
   output logic user_led14,
   output logic user_led15
);

   localparam int unsigned CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int unsigned CW  = bit_cnt_width(CPB);
   localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);

   // Reset asserts asynchronously and releases two clock edges later.
   logic [1:0] rst_sync_q;
   logic       rst;

   always_ff @(posedge clk100 or posedge user_btnc) begin
      if (user_btnc) rst_sync_q <= 2'b11;
      else           rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst = rst_sync_q[1];

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       frame_err;

   uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
      .clk_i       (clk100),
      .rst_i       (rst),
      .rx_i        (serial_rx),
      .rx_valid_o  (rx_valid),
      .rx_data_o   (rx_data),
      .frame_err_o (frame_err)
   );

   tx_state_e     tx_state_q;
   logic [CW-1:0] tx_cnt_q;
   logic [2:0]    tx_bit_q;
   logic [7:0]    tx_shift_q;
   logic          tx_q;
   logic [7:0]    hold_q;
   logic          hold_full_q;
   logic          tx_done_c, take_direct_c, drain_c, capture_c;

   // A new byte goes straight out if the line is free, else into the holding slot.
   assign tx_done_c     = (tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST);
   assign take_direct_c = rx_valid && ((tx_state_q == TX_IDLE) || (tx_done_c && !hold_full_q));
   assign drain_c       = tx_done_c && hold_full_q;
   assign capture_c     = rx_valid && !take_direct_c && (!hold_full_q || drain_c);

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         tx_q        <= 1'b1;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_q <= 1'b1;
               if (take_direct_c) begin
                  tx_state_q <= TX_START;
                  tx_cnt_q   <= '0;
                  tx_shift_q <= rx_data;
                  tx_q       <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
                  tx_q       <= tx_shift_q[0];
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_q <= TX_STOP;
                     tx_q       <= 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     tx_q       <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (drain_c || take_direct_c) begin
                     tx_state_q <= TX_START;
                     tx_shift_q <= drain_c ? hold_q : rx_data;
                     tx_q       <= 1'b0;
                  end else begin
                     tx_state_q <= TX_IDLE;
                     tx_q       <= 1'b1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
         if (drain_c) hold_full_q <= 1'b0;
         if (capture_c) begin
            hold_q      <= rx_data;
            hold_full_q <= 1'b1;
         end
      end
   end

   logic [7:0] led_byte_q;
   logic [6:0] led_cnt_q;
   logic       led_err_q;

   always_ff @(posedge clk100 or posedge rst) begin
      if (rst) begin
         led_byte_q <= '0;
         led_cnt_q  <= '0;
         led_err_q  <= 1'b0;
      end else begin
         if (rx_valid) begin
            led_byte_q <= rx_data;
            led_cnt_q  <= led_cnt_q + 7'd1;
         end
         if (frame_err) led_err_q <= 1'b1;
      end
   end

   assign serial_tx = tx_q;
   assign {user_led15, user_led14, user_led13, user_led12, user_led11, user_led10,
           user_led9, user_led8, user_led7, user_led6, user_led5, user_led4,
           user_led3, user_led2, user_led1, user_led0} = {led_err_q, led_cnt_q, led_byte_q};

endmodule

// File: tb/tb_digilent_basys3.sv
// Self-checking bench for the Basys3 UART echo: random frames against a
// byte-level model of LEDs, counter, error flag and echo stream.
module tb_digilent_basys3;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD_R = 58_000;
   localparam int CPB    = CLK_HZ / BAUD_R;      // 17 cycles per bit
   localparam int NS     = 9 * CPB + CPB / 2 + 1; // samples up to mid stop bit

   logic        clk       = 1'b0;
   logic        user_btnc = 1'b0;
   logic        serial_rx = 1'b1;
   logic        serial_tx;
   logic [15:0] leds;

   always #5 clk = ~clk;

   digilent_basys3 #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
      .clk100     (clk),
      .user_btnc  (user_btnc),
      .serial_rx  (serial_rx),
      .serial_tx  (serial_tx),
      .user_led0  (leds[0]),
      .user_led1  (leds[1]),
      .user_led2  (leds[2]),
      .user_led3  (leds[3]),
      .user_led4  (leds[4]),
      .user_led5  (leds[5]),
      .user_led6  (leds[6]),
      .user_led7  (leds[7]),
      .user_led8  (leds[8]),
      .user_led9  (leds[9]),
      .user_led10 (leds[10]),
      .user_led11 (leds[11]),
      .user_led12 (leds[12]),
      .user_led13 (leds[13]),
      .user_led14 (leds[14]),
      .user_led15 (leds[15])
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_byte = '0;
   int         exp_cnt  = 0;
   logic       exp_err  = 1'b0;
   logic [7:0] exp_echo[$];
   logic [7:0] got_echo[$];
   int         echo_rd  = 0;
   bit         mon_en   = 1'b0;
   int         tx_low_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_leds();
      return {exp_err, 7'(exp_cnt), exp_byte};
   endfunction

   // Independent decoder of serial_tx: samples each bit at its middle.
   initial begin : tx_mon
      logic       samp [NS];
      logic [7:0] b;
      bit         aborted;
      int         lead;
      wait (mon_en);
      forever begin
         @(negedge clk);
         if (!user_btnc && serial_tx == 1'b0) begin
            samp[0] = 1'b0;
            aborted = 1'b0;
            for (int k = 1; k < NS; k++) begin
               @(negedge clk);
               if (user_btnc) begin
                  aborted = 1'b1;
                  break;
               end
               samp[k] = serial_tx;
            end
            if (!aborted) begin
               for (int i = 0; i < 8; i++) b[i] = samp[(i + 1) * CPB + CPB / 2];
               check("tx_stop_bit", 32'(samp[9 * CPB + CPB / 2]), 32'd1);
               if (b[0]) begin
                  lead = 0;
                  while (lead < NS && samp[lead] == 1'b0) lead++;
                  check("tx_start_len", 32'(lead), 32'(CPB));
               end
               got_echo.push_back(b);
            end
         end
      end
   end

   initial begin : tx_low_counter
      forever begin
         @(negedge clk);
         if (mon_en && !user_btnc && serial_tx == 1'b0) tx_low_seen++;
      end
   end

   task automatic model_reset();
      exp_byte = '0;
      exp_cnt  = 0;
      exp_err  = 1'b0;
      exp_echo.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input bit good_stop);
      @(negedge clk);
      serial_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      serial_rx = good_stop;
      repeat (CPB) @(negedge clk);
      serial_rx = 1'b1;
      if (good_stop) begin
         exp_byte = b;
         exp_cnt  = (exp_cnt + 1) % 128;
         exp_echo.push_back(b);
      end else begin
         exp_err = 1'b1;
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic glitch(input int len);
      @(negedge clk);
      serial_rx = 1'b0;
      repeat (len) @(negedge clk);
      serial_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic reset_dut();
      user_btnc = 1'b1;
      repeat (5) @(negedge clk);
      user_btnc = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      echo_rd = got_echo.size();
   endtask

   task automatic drain_echo(input string tag);
      int n;
      int waited;
      n = exp_echo.size();
      waited = 0;
      while ((got_echo.size() - echo_rd) < n && waited < 40 * CPB) begin
         @(negedge clk);
         waited++;
      end
      repeat (2 * CPB) @(negedge clk);
      check({tag, "_echo_cnt"}, 32'(got_echo.size() - echo_rd), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (echo_rd < got_echo.size()) begin
            check({tag, "_echo_byte"}, 32'(got_echo[echo_rd]), 32'(exp_echo[i]));
            echo_rd++;
         end
      end
      echo_rd = got_echo.size();
      exp_echo.delete();
   endtask

   initial begin : main
      int base;
      int r;
      logic [7:0] b;

      // Power-on reset with the line idle.
      #2 user_btnc = 1'b1;
      #100;
      check("rst_tx", 32'(serial_tx), 32'd1);
      check("rst_leds", 32'(leds), 32'h0);
      @(negedge clk);
      user_btnc = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      mon_en = 1'b1;

      // Single known byte.
      send_frame(8'hA5, 1'b1);
      check("a5_leds", 32'(leds), 32'h01A5);
      drain_echo("a5");

      // Break: line low from reset release.
      user_btnc = 1'b1;
      serial_rx = 1'b0;
      repeat (5) @(negedge clk);
      base = tx_low_seen;
      user_btnc = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      check("brk_leds", 32'(leds), 32'h8000);
      check("brk_tx_low", 32'(tx_low_seen - base), 32'd0);
      check("brk_echo", 32'(got_echo.size() - echo_rd), 32'd0);
      serial_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("brk_release_leds", 32'(leds), 32'h8000);
      reset_dut();
      check("clr_leds", 32'(leds), 32'h0);

      // 130 back-to-back bytes: counter wraps to 2.
      for (int i = 0; i < 130; i++) begin
         send_frame(8'(i), 1'b1);
         check("b2b_leds", 32'(leds), 32'(exp_leds()));
      end
      check("wrap_leds", 32'(leds), 32'h0281);
      drain_echo("b2b");

      // Short low glitch on an idle line.
      glitch(CPB / 2 - 3);
      check("glitch_leds", 32'(leds), 32'(exp_leds()));
      drain_echo("glitch");

      // Random mix of good frames, glitches and framing errors.
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         b = 8'($urandom_range(0, 255));
         if (r == 0)      glitch(int'($urandom_range(1, CPB / 2 - 3)));
         else if (r == 1) send_frame(b, 1'b0);
         else             send_frame(b, 1'b1);
         check("rand_leds", 32'(leds), 32'(exp_leds()));
         repeat (int'($urandom_range(0, 2 * CPB))) @(negedge clk);
      end
      drain_echo("rand");

      // Reset in the middle of an echo, then a clean byte.
      send_frame(8'h5A, 1'b1);
      repeat (3 * CPB) @(negedge clk);
      user_btnc = 1'b1;
      #1;
      check("midrst_tx", 32'(serial_tx), 32'd1);
      check("midrst_leds", 32'(leds), 32'h0);
      repeat (5) @(negedge clk);
      user_btnc = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      echo_rd = got_echo.size();
      check("post_rst_tx", 32'(serial_tx), 32'd1);
      send_frame(8'h3C, 1'b1);
      check("3c_leds", 32'(leds), 32'h013C);
      drain_echo("3c");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digilent_basys3.md
DIGILENT_BASYS3 -- requirements
Module: digilent_basys3

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD, integer-truncated (868 at defaults).
REQ-003 clk100  input  1  sole clock, rising-edge.
REQ-004 user_btnc  input  1  reset, asynchronous, active-high (centre push-button).
REQ-005 serial_rx  input  1  UART receive line, 8N1, LSB first, idle high, asynchronous to clk100.
REQ-006 serial_tx  output  1  UART transmit line, 8N1, LSB first, idle high.
REQ-007 user_led0..user_led15  output  1 each  status LEDs, active-high, registered.

Function
REQ-008 serial_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-009 RX states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-010 IDLE -> START on a synchronized high-to-low transition.
REQ-011 START: sample at CLKS_PER_BIT/2 cycles after the edge; low -> DATA, high -> IDLE (false start, nothing reported).
REQ-012 DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, LSB first; then STOP.
REQ-013 STOP: sample one bit time later; high -> one-cycle rx_valid with the byte, then IDLE; low -> framing error, no rx_valid, then WAIT_IDLE.
REQ-014 WAIT_IDLE SHALL hold until synchronized serial_rx is high, then return to IDLE; a permanently low line (break) SHALL never produce bytes.
REQ-015 On rx_valid, user_led7..0 SHALL load the byte (led0 = bit0) on the next clock edge.
REQ-016 On rx_valid, a 7-bit counter on user_led14..8 (led8 = LSB) SHALL increment, wrapping 127 -> 0.
REQ-017 On framing error, user_led15 SHALL be set; it stays set until reset.
REQ-018 Each valid byte SHALL be echoed on serial_tx.
REQ-019 TX states SHALL be IDLE, START, DATA, STOP; each bit lasts exactly CLKS_PER_BIT cycles; frame is start(0), 8 data LSB first, stop(1).
REQ-020 If TX is IDLE at rx_valid, the start bit SHALL appear on serial_tx on the clock edge after rx_valid.
REQ-021 If TX is busy, the byte goes to a one-entry holding register and is sent immediately after the current stop bit.
REQ-022 If TX is busy and the holding register is full, the new byte is not echoed; LED and counter updates still occur.
REQ-023 serial_tx SHALL be driven from a flop and be high whenever TX is IDLE.

Reset
REQ-024 While user_btnc is high, and asynchronously on its assertion: serial_tx = 1, all LEDs = 0, counter = 0, holding register empty, RX and TX in IDLE.
REQ-025 Reset deassertion SHALL be synchronized to clk100; operation resumes on the second rising edge after release.
REQ-026 Reset during a frame SHALL abort it; the partial byte is discarded and never echoed.

Structure
REQ-027 Package digilent_basys3_pkg SHALL hold the RX/TX state enums and the CLKS_PER_BIT derivation function.
REQ-028 One sub-module, uart_rx (synchronizer, RX FSM, rx_valid/rx_data/frame_err outputs), is instantiated.
REQ-029 TX FSM, holding register, LED and counter logic SHALL live in the top.
REQ-030 Bit counters SHALL be ceil(log2(CLKS_PER_BIT)) bits wide; no other clocks or latches.

Verification
REQ-031 Reset high 100 ns, rx idle high -> serial_tx = 1, all LEDs 0.
REQ-032 Send 0xA5 at 115200 -> LEDs7..0 = 10100101, LEDs14..8 = 1, led15 = 0; serial_tx emits 0xA5 frame, bit period 868 cycles.
REQ-033 Hold serial_rx low from reset release for 20 bit times -> one framing error only, led15 = 1, count 0, serial_tx stays high.
REQ-034 Send 130 back-to-back bytes 0x00..0x81 -> count = 2 (wrap), LEDs7..0 = 0x81, all 130 bytes echoed in order.
REQ-035 Low glitch of 100 cycles on idle serial_rx -> no byte, LEDs unchanged.
REQ-036 Assert user_btnc mid-byte during an echo -> serial_tx high immediately, all LEDs 0; next byte 0x3C is received and echoed correctly.
